// File: rtl/ram_collect_mux.sv
// ram_collect_mux: round-robin collector that writes neuron-unit result words back to RAM.
// Optional COLLECT_WRCOUNT_EN adds the 16-bit completed-write counter output wr_count.
module ram_collect_mux #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_UNITS   = 6,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic [N_UNITS*WIDTH-1:0]   unit_result,
    input  logic [N_UNITS-1:0]         unit_valid,
    output logic [N_UNITS-1:0]         unit_ack,
    output logic [3:0]                 unit_sel,
    output logic [WIDTH-1:0]           ram_wdata,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_we,
    input  logic                       ram_ready,
    input  logic                       clear,
    output logic                       busy,
    output logic                       all_done
`ifdef COLLECT_WRCOUNT_EN
    ,
    output logic [15:0]                wr_count
`endif
);

    localparam int unsigned SEL_W = 4;
    localparam int          NU    = int'(N_UNITS);
    localparam logic [N_UNITS-1:0] ALL_WRITTEN = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [N_UNITS-1:0]   written_q, written_d;
    logic [N_UNITS-1:0]   unit_ack_q, unit_ack_d;
    logic [SEL_W-1:0]     unit_sel_q, unit_sel_d;
    logic [WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic                 ram_we_q, ram_we_d;
    logic                 busy_q, busy_d;
    logic                 all_done_q, all_done_d;

    logic                 any_valid_c;
    logic [SEL_W-1:0]     pick_c;
    logic [WIDTH-1:0]     pick_word_c;
    logic [N_UNITS-1:0]   sel_onehot_c;
    logic                 complete_c;
    logic [SEL_W-1:0]     lo_idx_c;
    logic [SEL_W-1:0]     hi_idx_c;
    logic                 hi_found_c;

    // Round-robin pick: lowest valid index at/after ptr, else lowest valid overall (wrap).
    always_comb begin
        lo_idx_c   = '0;
        hi_idx_c   = '0;
        hi_found_c = 1'b0;
        for (int k = NU - 1; k >= 0; k--) begin
            if (unit_valid[k]) begin
                lo_idx_c = SEL_W'(k);
                if (SEL_W'(k) >= ptr_q) begin
                    hi_idx_c   = SEL_W'(k);
                    hi_found_c = 1'b1;
                end
            end
        end
        any_valid_c = |unit_valid;
        pick_c      = hi_found_c ? hi_idx_c : lo_idx_c;
    end

    always_comb begin
        pick_word_c = '0;
        for (int k = 0; k < NU; k++) begin
            if (pick_c == SEL_W'(k)) begin
                pick_word_c = unit_result[k*int'(WIDTH) +: WIDTH];
            end
        end
    end

    always_comb begin
        sel_onehot_c = '0;
        for (int k = 0; k < NU; k++) begin
            sel_onehot_c[k] = (unit_sel_q == SEL_W'(k));
        end
    end

    // Collection FSM: latch in IDLE, hold the write until accepted, one ack cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        unit_ack_d  = '0;
        unit_sel_d  = unit_sel_q;
        ram_wdata_d = ram_wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        complete_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_c) begin
                    unit_sel_d  = pick_c;
                    ram_wdata_d = pick_word_c;
                    ram_addr_d  = ADDR_W'(BASE_ADDR + 32'(pick_c));
                    ram_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ram_ready) begin
                    complete_c = 1'b1;
                    ram_we_d   = 1'b0;
                    unit_ack_d = sel_onehot_c;
                    ptr_d      = (unit_sel_q == SEL_W'(N_UNITS - 1)) ? '0
                                                                     : unit_sel_q + SEL_W'(1);
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                ram_we_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Round tracker: a full round self-clears one cycle after all_done; clear keeps a same-cycle completion.
    always_comb begin
        written_d = (written_q == ALL_WRITTEN) ? '0 : written_q;
        if (clear) begin
            written_d = '0;
        end
        if (complete_c) begin
            written_d = written_d | sel_onehot_c;
        end
        all_done_d = complete_c && (written_d == ALL_WRITTEN);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            written_q   <= '0;
            unit_ack_q  <= '0;
            unit_sel_q  <= '0;
            ram_wdata_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            written_q   <= written_d;
            unit_ack_q  <= unit_ack_d;
            unit_sel_q  <= unit_sel_d;
            ram_wdata_q <= ram_wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            all_done_q  <= all_done_d;
        end
    end

    assign unit_ack  = unit_ack_q;
    assign unit_sel  = unit_sel_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;
    assign all_done  = all_done_q;

`ifdef COLLECT_WRCOUNT_EN
    logic [15:0] wr_count_q, wr_count_d;

    // Completed-write counter; a completion coincident with clear counts as the first write.
    always_comb begin
        wr_count_d = clear ? 16'd0 : wr_count_q;
        if (complete_c) begin
            wr_count_d = wr_count_d + 16'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram_collect_mux.sv
// Scoreboard bench for ram_collect_mux: expected writes queued at stimulus time, checked at each RAM handshake.
module tb_ram_collect_mux;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned N_UNITS   = 6;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned BASE_ADDR = 252;
    localparam int          NU        = int'(N_UNITS);
    localparam logic [N_UNITS-1:0] ALL_ONES = '1;

    logic                     CLOCK = 1'b0;
    logic                     RESET_N = 1'b0;
    logic [N_UNITS*WIDTH-1:0] unit_result;
    logic [N_UNITS-1:0]       unit_valid;
    logic [N_UNITS-1:0]       unit_ack;
    logic [3:0]               unit_sel;
    logic [WIDTH-1:0]         ram_wdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     ram_we;
    logic                     ram_ready;
    logic                     clear;
    logic                     busy;
    logic                     all_done;
`ifdef COLLECT_WRCOUNT_EN
    logic [15:0]              wr_count;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        int                unit;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               mptr = 0;
    logic [WIDTH-1:0] words[N_UNITS];

    always #5 CLOCK = ~CLOCK;

    always_comb begin
        for (int k = 0; k < NU; k++) begin
            unit_result[k*int'(WIDTH) +: WIDTH] = words[k];
        end
    end

    ram_collect_mux #(
        .WIDTH(WIDTH), .N_UNITS(N_UNITS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .unit_result(unit_result),
        .unit_valid(unit_valid),
        .unit_ack(unit_ack),
        .unit_sel(unit_sel),
        .ram_wdata(ram_wdata),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_ready(ram_ready),
        .clear(clear),
        .busy(busy),
        .all_done(all_done)
`ifdef COLLECT_WRCOUNT_EN
        ,
        .wr_count(wr_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise valid for the units in mask and queue their writes in round-robin service order.
    task automatic raise(input logic [N_UNITS-1:0] mask);
        logic [N_UNITS-1:0] m;
        int idx;
        m = mask;
        unit_valid = unit_valid | mask;
        while (m != '0) begin
            idx = mptr;
            while (!m[idx]) idx = (idx + 1) % NU;
            sb.push_back('{addr: ADDR_W'(BASE_ADDR + 32'(idx)), data: words[idx], unit: idx});
            m[idx] = 1'b0;
            mptr = (idx + 1) % NU;
        end
    endtask

    // Advance one clock; units drop valid as soon as their ack is seen.
    task automatic cyc();
        @(posedge CLOCK);
        #1;
        unit_valid = unit_valid & ~unit_ack;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < max_cyc) begin
            cyc();
            n++;
        end
        check("drain_timeout", 64'(n >= max_cyc), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    64'(ram_we),    64'(0));
        check({tag, "_ack"},   64'(unit_ack),  64'(0));
        check({tag, "_sel"},   64'(unit_sel),  64'(0));
        check({tag, "_wdata"}, 64'(ram_wdata), 64'(0));
        check({tag, "_addr"},  64'(ram_addr),  64'(0));
        check({tag, "_busy"},  64'(busy),      64'(0));
        check({tag, "_done"},  64'(all_done),  64'(0));
    endtask

    // Per-cycle monitor: handshakes against the scoreboard, ack/all_done/count against a round model.
    int                 pend_unit = -1;
    logic               exp_done = 1'b0;
    logic [N_UNITS-1:0] mw = '0;
    logic [N_UNITS-1:0] nw;
    logic [15:0]        mcnt = '0;
    int                 cycle = 0;
    int                 last_hs = -1;
    logic               spacing_en = 1'b0;
    logic               hs;
    exp_t               e;

    always @(negedge CLOCK) begin
        cycle++;
        if (!spacing_en) last_hs = -1;
        if (!RESET_N) begin
            pend_unit = -1;
            exp_done  = 1'b0;
            mw        = '0;
            mcnt      = '0;
        end else begin
            check("unit_ack", 64'(unit_ack), (pend_unit < 0) ? 64'(0) : (64'(1) << pend_unit));
            check("all_done", 64'(all_done), 64'(exp_done));
`ifdef COLLECT_WRCOUNT_EN
            check("wr_count", 64'(wr_count), 64'(mcnt));
`endif
            hs = ram_we && ram_ready;
            nw = (mw == ALL_ONES) ? '0 : mw;
            if (clear) nw = '0;
            pend_unit = -1;
            if (hs) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("ram_addr",  64'(ram_addr),  64'(e.addr));
                    check("ram_wdata", 64'(ram_wdata), 64'(e.data));
                    check("unit_sel",  64'(unit_sel),  64'(e.unit));
                    pend_unit = e.unit;
                    nw[e.unit] = 1'b1;
                end
                if (spacing_en && last_hs >= 0) check("hs_spacing", 64'(cycle - last_hs), 64'(3));
                last_hs = cycle;
            end
            exp_done = hs && (nw == ALL_ONES);
            mw       = nw;
            mcnt     = (clear ? 16'd0 : mcnt) + (hs ? 16'd1 : 16'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        unit_valid = '0;
        ram_ready  = 1'b0;
        clear      = 1'b0;
        for (int k = 0; k < NU; k++) words[k] = '0;
        repeat (3) cyc();
        check_outputs_zero("reset");
        RESET_N = 1'b1;
        cyc();

        // Full round from ptr 0: units 0..5 at 3-cycle spacing, all_done after unit 5.
        for (int k = 0; k < NU; k++) words[k] = WIDTH'(1) << k;
        ram_ready  = 1'b1;
        spacing_en = 1'b1;
        raise(6'h3F);
        drain(60);
        spacing_en = 1'b0;

        // Single unit with explicit latency.
        words[2] = 32'h4;
        raise(6'b000100);
        cyc();
        check("t1_we",    64'(ram_we),    64'(1));
        check("t1_addr",  64'(ram_addr),  64'(254));
        check("t1_wdata", 64'(ram_wdata), 64'(4));
        check("t1_busy",  64'(busy),      64'(1));
        cyc();
        check("t1_we_drop", 64'(ram_we),  64'(0));
        cyc();
        check("t1_idle",  64'(busy),      64'(0));
        drain(10);

        // Fairness: ptr moves to 4, then units 1 and 5 contend; 5 goes first.
        words[3] = 32'h3333_0003;
        raise(6'b001000);
        drain(10);
        words[1] = 32'h1111_0001;
        words[5] = 32'h5555_0005;
        raise(6'b100010);
        drain(20);

        // Stall: write held stable while ram_ready is low.
        ram_ready = 1'b0;
        words[0]  = 32'hDEAD_BEEF;
        raise(6'b000001);
        cyc();
        for (int s = 0; s < 5; s++) begin
            cyc();
            check("stall_we",    64'(ram_we),    64'(1));
            check("stall_addr",  64'(ram_addr),  64'(252));
            check("stall_wdata", 64'(ram_wdata), 64'(32'hDEAD_BEEF));
        end
        ram_ready = 1'b1;
        drain(10);

        // Reset mid-WRITE drops the word; the still-valid unit is collected again (addr wraps to 0).
        ram_ready = 1'b0;
        words[4]  = 32'hA5A5_0004;
        raise(6'b010000);
        cyc();
        cyc();
        check("t5_we_before", 64'(ram_we), 64'(1));
        RESET_N = 1'b0;
        #1;
        check_outputs_zero("t5_reset");
        sb.delete();
        mptr = 0;
        repeat (2) cyc();
        RESET_N = 1'b1;
        raise(6'b010000);
        ram_ready = 1'b1;
        drain(20);

        // clear together with unit 3's completion keeps only bit 3; the rest of the round then completes.
        ram_ready = 1'b0;
        words[3]  = 32'h0000_3333;
        raise(6'b001000);
        cyc();
        ram_ready = 1'b1;
        clear     = 1'b1;
        cyc();
        clear     = 1'b0;
`ifdef COLLECT_WRCOUNT_EN
        check("t6_wr_count", 64'(wr_count), 64'(1));
`endif
        drain(10);
        for (int k = 0; k < NU; k++) words[k] = 32'hC0DE_0000 | WIDTH'(k);
        raise(6'b110111);
        drain(60);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
